// File: rtl/scan_test_sequencer.sv
// Scan-test sequencer: fetches pattern lines, shifts/captures/unloads the CUT scan chain,
// and reports pass/fail, mismatch count and first failing pattern address.
module scan_test_sequencer #(
  parameter int unsigned NFF          = 26,
  parameter int unsigned IN_SIZE      = 8,
  parameter int unsigned OUT_SIZE     = 8,
  parameter int unsigned ADDR_W       = 8,
  parameter bit          STOP_ON_FAIL = 1'b1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [ADDR_W-1:0]                 num_patterns,
  output logic [ADDR_W-1:0]                 pat_addr,
  output logic                              pat_rd,
  input  logic [2*NFF+IN_SIZE+OUT_SIZE-1:0] pat_data,
  output logic                              NbarT,
  output logic                              si,
  input  logic                              so,
  output logic [IN_SIZE-1:0]                data_bus_in,
  input  logic [OUT_SIZE-1:0]               data_bus_out,
  output logic                              busy,
  output logic                              done,
  output logic                              fail,
  output logic [ADDR_W-1:0]                 fail_addr,
  output logic [ADDR_W-1:0]                 mismatch_count
);

  localparam int unsigned LINE_SIZE = 2*NFF + IN_SIZE + OUT_SIZE;
  localparam int unsigned PI_IDX    = NFF + OUT_SIZE;
  localparam int unsigned ST_IDX    = NFF + OUT_SIZE + IN_SIZE;
  localparam int unsigned CNT_W     = (NFF > 1) ? $clog2(NFF) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_LOAD, S_SHIFT, S_CAPTURE, S_COMPARE, S_UNLOAD, S_FINAL, S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_W-1:0]     idx_q, idx_d;
  logic [ADDR_W-1:0]     num_q, num_d;
  logic [LINE_SIZE-1:0]  line_q, line_d;
  logic [NFF-1:0]        prev_exp_q, prev_exp_d;
  logic [NFF-1:0]        resp_q, resp_d;
  logic [OUT_SIZE-1:0]   po_q, po_d;
  logic [ADDR_W-1:0]     pat_addr_q, pat_addr_d;
  logic                  pat_rd_q, pat_rd_d;
  logic                  nbart_q, nbart_d;
  logic                  si_q, si_d;
  logic [IN_SIZE-1:0]    din_q, din_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  fail_q, fail_d;
  logic [ADDR_W-1:0]     fail_addr_q, fail_addr_d;
  logic [ADDR_W-1:0]     mcount_q, mcount_d;
  logic                  mismatch_c;
  logic [ADDR_W-1:0]     cmp_addr_c;
  logic [NFF-1:0]        scan_c;
  logic                  cnt_last_c;

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    num_d       = num_q;
    line_d      = line_q;
    prev_exp_d  = prev_exp_q;
    resp_d      = resp_q;
    po_d        = po_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    mcount_d    = mcount_q;
    mismatch_c  = 1'b0;
    cmp_addr_c  = idx_q;
    cnt_last_c  = (cnt_q == CNT_W'(NFF-1));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          fail_d      = 1'b0;
          fail_addr_d = '0;
          mcount_d    = '0;
          idx_d       = '0;
          num_d       = num_patterns;
          prev_exp_d  = '0;
          state_d     = (num_patterns == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        line_d  = pat_data;
        cnt_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        resp_d = {so, resp_q[NFF-1:1]};
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_last_c) begin
          cnt_d   = '0;
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        po_d    = data_bus_out;
        state_d = S_COMPARE;
      end
      S_COMPARE: begin
        mismatch_c = ({prev_exp_q, line_q[OUT_SIZE-1:0]} != {resp_q, po_q});
        prev_exp_d = line_q[PI_IDX-1:OUT_SIZE];
        idx_d      = idx_q + ADDR_W'(1);
        cnt_d      = '0;
        if (mismatch_c && STOP_ON_FAIL) state_d = S_DONE;
        else if (idx_d == num_q)        state_d = S_UNLOAD;
        else                            state_d = S_FETCH;
      end
      S_UNLOAD: begin
        resp_d = {so, resp_q[NFF-1:1]};
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_last_c) begin
          cnt_d   = '0;
          state_d = S_FINAL;
        end
      end
      S_FINAL: begin
        // Last captured state has no PO to compare; its address is reported as num_patterns
        mismatch_c = (prev_exp_q != resp_q);
        cmp_addr_c = num_q;
        state_d    = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (mismatch_c) begin
      fail_d = 1'b1;
      if (!fail_q)          fail_addr_d = cmp_addr_c;
      if (mcount_q != '1)   mcount_d    = mcount_q + ADDR_W'(1);
    end

    scan_c     = line_d[LINE_SIZE-1:ST_IDX];
    pat_rd_d   = (state_d == S_FETCH);
    pat_addr_d = (state_d == S_FETCH) ? idx_d : pat_addr_q;
    nbart_d    = (state_d inside {S_SHIFT, S_UNLOAD});
    si_d       = (state_d == S_SHIFT) ? scan_c[cnt_d] : 1'b0;
    din_d      = (state_d == S_SHIFT) ? line_d[ST_IDX-1:PI_IDX] : din_q;
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      num_q       <= '0;
      line_q      <= '0;
      prev_exp_q  <= '0;
      resp_q      <= '0;
      po_q        <= '0;
      pat_addr_q  <= '0;
      pat_rd_q    <= 1'b0;
      nbart_q     <= 1'b0;
      si_q        <= 1'b0;
      din_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      mcount_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      num_q       <= num_d;
      line_q      <= line_d;
      prev_exp_q  <= prev_exp_d;
      resp_q      <= resp_d;
      po_q        <= po_d;
      pat_addr_q  <= pat_addr_d;
      pat_rd_q    <= pat_rd_d;
      nbart_q     <= nbart_d;
      si_q        <= si_d;
      din_q       <= din_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      mcount_q    <= mcount_d;
    end
  end

  assign pat_addr       = pat_addr_q;
  assign pat_rd         = pat_rd_q;
  assign NbarT          = nbart_q;
  assign si             = si_q;
  assign data_bus_in    = din_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign fail           = fail_q;
  assign fail_addr      = fail_addr_q;
  assign mismatch_count = mcount_q;

endmodule

// File: tb/tb_scan_test_sequencer.sv
// Directed bench for scan_test_sequencer: instance 0 stops on first fail, instance 1 runs all patterns.
// Each instance drives its own shift-register CUT model and registered pattern memory.
module tb_scan_test_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        mon_clr;
  logic        start [2];
  logic [7:0]  num [2];
  logic [67:0] mem [2][8];

  logic [7:0]  pat_addr [2];
  logic        pat_rd [2];
  logic        nbart [2];
  logic        si [2];
  logic [7:0]  din [2];
  logic        busy [2];
  logic        done [2];
  logic        fail [2];
  logic [7:0]  fail_addr [2];
  logic [7:0]  mcount [2];
  logic        rd_seen [2];
  logic [7:0]  max_addr [2];
  int          done_cnt [2];

  int n_cmp = 0;
  int n_fail = 0;
  int k;

  logic [25:0] sv [4] = '{26'h1234567, 26'h0ABCDEF, 26'h3FFFFFF, 26'h0000001};
  logic [7:0]  pv [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h01};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [67:0] pd_q;
    logic [25:0] cut_q;
    logic        nbp_q;
    logic [7:0]  pa, dbi, fa, mc, max_l;
    logic        rd, nb, s_i, bz, dn, fl, rd_seen_l;
    int          dcnt_l;

    scan_test_sequencer #(
      .NFF(26), .IN_SIZE(8), .OUT_SIZE(8), .ADDR_W(8), .STOP_ON_FAIL(g == 0)
    ) u_dut (
      .clk(clk), .reset(reset), .start(start[g]), .num_patterns(num[g]),
      .pat_addr(pa), .pat_rd(rd), .pat_data(pd_q),
      .NbarT(nb), .si(s_i), .so(cut_q[0]),
      .data_bus_in(dbi), .data_bus_out(cut_q[7:0]),
      .busy(bz), .done(dn), .fail(fl), .fail_addr(fa), .mismatch_count(mc)
    );

    always @(posedge clk) if (rd) pd_q <= mem[g][pa[2:0]];

    // CUT: right-shifting chain in scan mode, captures once on the first functional edge after shifting
    always @(posedge clk or negedge reset) begin
      if (!reset) begin
        cut_q <= '0;
        nbp_q <= 1'b0;
      end else begin
        nbp_q <= nb;
        if (nb)         cut_q <= {s_i, cut_q[25:1]};
        else if (nbp_q) cut_q <= cut_q ^ {dbi, dbi, dbi, dbi[1:0]};
      end
    end

    always @(posedge clk) begin
      if (mon_clr) begin
        rd_seen_l <= 1'b0;
        max_l     <= '0;
        dcnt_l    <= 0;
      end else begin
        if (rd) begin
          rd_seen_l <= 1'b1;
          if (pa > max_l) max_l <= pa;
        end
        if (dn) dcnt_l <= dcnt_l + 1;
      end
    end

    assign pat_addr[g]  = pa;
    assign pat_rd[g]    = rd;
    assign nbart[g]     = nb;
    assign si[g]        = s_i;
    assign din[g]       = dbi;
    assign busy[g]      = bz;
    assign done[g]      = dn;
    assign fail[g]      = fl;
    assign fail_addr[g] = fa;
    assign mcount[g]    = mc;
    assign rd_seen[g]   = rd_seen_l;
    assign max_addr[g]  = max_l;
    assign done_cnt[g]  = dcnt_l;
  end

  function automatic logic [67:0] mk_line(input logic [25:0] s, input logic [7:0] p);
    logic [25:0] ns;
    ns = s ^ {p, p, p, p[1:0]};
    return {s, p, ns, s[7:0]};
  endfunction

  task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    mon_clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    mon_clr = 1'b0;
  endtask

  task automatic pulse_start(input int g, input logic [7:0] n);
    num[g]   = n;
    start[g] = 1'b1;
    k        = 0;
    step();
    start[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int lim, input string tag);
    while (done[g] !== 1'b1 && k < lim) step();
    chk({tag, "_done"}, 68'(done[g]), 68'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    start   = '{1'b0, 1'b0};
    num     = '{8'd0, 8'd0};
    reset   = 1'b0;
    mon_clr = 1'b1;
    for (int a = 0; a < 8; a++) begin
      mem[0][a] = '0;
      mem[1][a] = '0;
    end
    do_reset();

    // Reset state of both instances
    for (int g = 0; g < 2; g++)
      chk("reset_outputs", 68'({pat_addr[g], pat_rd[g], nbart[g], si[g], din[g], busy[g],
                                done[g], fail[g], fail_addr[g], mcount[g]}), 68'(0));

    // T1: single passing pattern, timing and first shift bits
    mem[0][0] = mk_line(26'h2AAAAAA, 8'h5C);
    pulse_start(0, 8'd1);
    chk("t1_fetch", 68'({busy[0], pat_rd[0], pat_addr[0]}), 68'({1'b1, 1'b1, 8'd0}));
    step(); step();
    chk("t1_shift0", 68'({nbart[0], si[0], din[0]}), 68'({1'b1, 1'b0, 8'h5C}));
    step();
    chk("t1_shift1", 68'({nbart[0], si[0]}), 68'({1'b1, 1'b1}));
    wait_done(0, 200, "t1");
    chk("t1_cycles", 68'(k), 68'(1*30 + 28));
    chk("t1_result", 68'({fail[0], mcount[0], busy[0]}), 68'({1'b0, 8'd0, 1'b1}));
    step();
    chk("t1_after", 68'({busy[0], done[0], nbart[0]}), 68'(0));

    // T2: stop on first fail, PO of addr 2 corrupted
    do_reset();
    for (int a = 0; a < 4; a++) mem[0][a] = mk_line(sv[a], pv[a]);
    mem[0][2] = mem[0][2] ^ 68'h1;
    pulse_start(0, 8'd4);
    wait_done(0, 400, "t2");
    chk("t2_cycles", 68'(k), 68'(91));
    chk("t2_fail", 68'({fail[0], fail_addr[0], mcount[0]}), 68'({1'b1, 8'd2, 8'd1}));
    chk("t2_max_addr", 68'(max_addr[0]), 68'(2));

    // T3: run-all instance, addrs 1 and 3 corrupted
    do_reset();
    for (int a = 0; a < 4; a++) mem[1][a] = mk_line(sv[a], pv[a]);
    mem[1][1] = mem[1][1] ^ 68'h1;
    mem[1][3] = mem[1][3] ^ 68'h80;
    pulse_start(1, 8'd4);
    wait_done(1, 400, "t3");
    chk("t3_cycles", 68'(k), 68'(4*30 + 28));
    chk("t3_fail", 68'({fail[1], fail_addr[1], mcount[1]}), 68'({1'b1, 8'd1, 8'd2}));
    chk("t3_max_addr", 68'(max_addr[1]), 68'(3));

    // T4: zero patterns
    do_reset();
    pulse_start(0, 8'd0);
    chk("t4_done_now", 68'({done[0], k}), 68'({1'b1, 32'd1}));
    step();
    chk("t4_after", 68'({busy[0], fail[0], rd_seen[0]}), 68'(0));

    // T5: reset during SHIFT i=10, then clean restart
    do_reset();
    mem[0][0] = mk_line(26'h2AAAAAA, 8'h5C);
    pulse_start(0, 8'd1);
    while (k < 13) step();
    chk("t5_in_shift", 68'({nbart[0], busy[0]}), 68'(2'b11));
    reset = 1'b0;
    #1;
    chk("t5_abort", 68'({nbart[0], si[0], busy[0], done[0]}), 68'(0));
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    step(); step();
    chk("t5_no_done", 68'(done_cnt[0]), 68'(0));
    pulse_start(0, 8'd1);
    chk("t5_restart", 68'({pat_rd[0], pat_addr[0]}), 68'({1'b1, 8'd0}));
    wait_done(0, 200, "t5");
    chk("t5_result", 68'({k, fail[0]}), 68'({32'd58, 1'b0}));

    // T6: wrong exp state on last line caught at final unload; mid-run start ignored
    do_reset();
    for (int a = 0; a < 3; a++) mem[0][a] = mk_line(sv[a], pv[a]);
    mem[0][2] = mem[0][2] ^ (68'h1 << 8);
    pulse_start(0, 8'd3);
    while (k < 40) step();
    num[0]   = 8'd1;
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    wait_done(0, 400, "t6");
    chk("t6_cycles", 68'(k), 68'(3*30 + 28));
    chk("t6_fail", 68'({fail[0], fail_addr[0], mcount[0]}), 68'({1'b1, 8'd3, 8'd1}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
